// File: rtl/aes_round_sequencer_if.sv
// ---------------------------------------------------------------------------
// aes_round_sequencer_if
//   Bundles every non-clock signal of the iterative AES-128 round sequencer:
//   the job request handshake, the result handshake and the link to the
//   external combinational round datapath.
//
//   master : the environment (requester, consumer and round datapath)
//   slave  : the sequencer itself
//
//   in_valid/in_ready/Plain_Text/Key  job request handshake
//   abort                             synchronous job drop
//   out_valid/out_ready/Cipher_Text   result handshake
//   busy                              sequencer is not idle
//   dp_state/dp_key/dp_round/dp_last  operands presented to the datapath
//   dp_state_next/dp_key_next         datapath results for the current round
// ---------------------------------------------------------------------------
interface aes_round_sequencer_if #(
   parameter int LENGTH = 128,
   parameter int RW     = 4
);
   logic              in_valid;
   logic              in_ready;
   logic [LENGTH-1:0] Plain_Text;
   logic [LENGTH-1:0] Key;
   logic              abort;
   logic              out_valid;
   logic              out_ready;
   logic [LENGTH-1:0] Cipher_Text;
   logic              busy;
   logic [LENGTH-1:0] dp_state;
   logic [LENGTH-1:0] dp_key;
   logic [RW-1:0]     dp_round;
   logic              dp_last;
   logic [LENGTH-1:0] dp_state_next;
   logic [LENGTH-1:0] dp_key_next;

   modport master (
      output in_valid, Plain_Text, Key, abort, out_ready, dp_state_next, dp_key_next,
      input  in_ready, out_valid, Cipher_Text, busy, dp_state, dp_key, dp_round, dp_last
   );

   modport slave (
      input  in_valid, Plain_Text, Key, abort, out_ready, dp_state_next, dp_key_next,
      output in_ready, out_valid, Cipher_Text, busy, dp_state, dp_key, dp_round, dp_last
   );
endinterface

// File: rtl/aes_round_sequencer.sv
// ---------------------------------------------------------------------------
// aes_round_sequencer
//   Iterative AES-128 encryption controller around one shared, external,
//   combinational round datapath (SubBytes, ShiftRows, optional MixColumns,
//   AddRoundKey, KeyExpansion). Owns the state and round-key registers, the
//   round counter, the IDLE/ROUND/DONE FSM and both valid/ready handshakes.
//   One block takes NR+1 cycles from accept to the next possible accept.
//
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : aes_round_sequencer_if slave port (request, result, datapath)
// ---------------------------------------------------------------------------
module aes_round_sequencer #(
   parameter int LENGTH = 128,
   parameter int NR     = 10,
   parameter int RW     = 4
) (
   input logic                 clk,
   input logic                 rst,
   aes_round_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } fsm_e;

   localparam logic [3:0] LAST_ROUND = 4'(NR);

   fsm_e              fsm_q, fsm_d;
   logic [3:0]        round_q, round_d;
   logic [LENGTH-1:0] state_q, state_d;
   logic [LENGTH-1:0] key_q, key_d;
   logic [LENGTH-1:0] cipher_q, cipher_d;
   logic              out_valid_q, out_valid_d;

   logic              in_ready;
   logic              busy;
   logic [RW-1:0]     dp_round;
   logic              dp_last;
   logic              last_round;
   logic              accept;

   assign last_round = (round_q == LAST_ROUND);
   assign accept     = bus.in_valid && in_ready;

   // ------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------
   // NOTE: clocked processes use non-blocking (<=) so every flop samples
   // the pre-edge value of every other flop; blocking here creates
   // simulation races and sim/synthesis mismatches.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q <= IDLE;
      end else begin
         fsm_q <= fsm_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM next-state logic
   // ------------------------------------------------------------------
   // NOTE: every always_comb output gets a default before any branch, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      fsm_d = fsm_q;
      case (fsm_q)
         IDLE:    if (accept) fsm_d = ROUND;
         ROUND:   if (last_round) fsm_d = DONE;
         // A new job may be accepted in the same cycle the result leaves.
         DONE:    if (bus.out_ready) fsm_d = accept ? ROUND : IDLE;
         default: fsm_d = IDLE;
      endcase
      if (bus.abort) fsm_d = IDLE;
   end

   // ------------------------------------------------------------------
   // FSM outputs
   // ------------------------------------------------------------------
   always_comb begin
      in_ready = !bus.abort && ((fsm_q == IDLE) || ((fsm_q == DONE) && bus.out_ready));
      busy     = (fsm_q != IDLE);
      dp_round = (fsm_q == ROUND) ? RW'(round_q) : '0;
      dp_last  = (fsm_q == ROUND) && last_round;
   end

   // ------------------------------------------------------------------
   // Datapath registers: next values
   // ------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      key_d       = key_q;
      cipher_d    = cipher_q;
      round_d     = round_q;
      out_valid_d = out_valid_q;
      if (bus.abort) begin
         // The job is dropped; state, key and last result are left as-is.
         round_d     = '0;
         out_valid_d = 1'b0;
      end else if (accept) begin
         // Round-0 AddRoundKey happens here so the datapath only ever
         // sees full rounds 1..NR.
         state_d     = bus.Plain_Text ^ bus.Key;
         key_d       = bus.Key;
         round_d     = 4'd1;
         out_valid_d = 1'b0;
      end else if (fsm_q == ROUND) begin
         state_d = bus.dp_state_next;
         key_d   = bus.dp_key_next;
         if (last_round) begin
            cipher_d    = bus.dp_state_next;
            out_valid_d = 1'b1;
            round_d     = '0;
         end else begin
            round_d = round_q + 4'd1;
         end
      end else if ((fsm_q == DONE) && bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   // The wide state/key registers are reset too, so no key material from
   // an interrupted job remains visible on dp_state/dp_key after rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         round_q     <= '0;
         state_q     <= '0;
         key_q       <= '0;
         cipher_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         round_q     <= round_d;
         state_q     <= state_d;
         key_q       <= key_d;
         cipher_q    <= cipher_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.busy        = busy;
   assign bus.out_valid   = out_valid_q;
   assign bus.Cipher_Text = cipher_q;
   assign bus.dp_state    = state_q;
   assign bus.dp_key      = key_q;
   assign bus.dp_round    = dp_round;
   assign bus.dp_last     = dp_last;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// ---------------------------------------------------------------------------
// tb_aes_round_sequencer
//   Drives the sequencer with directed FIPS-197 jobs while a behavioural
//   AES-128 round datapath closes the loop on dp_*. A job-level model
//   (cycles since accept, pending result) predicts every output and is
//   compared on each falling edge; literal FIPS ciphertexts pin the model.
// ---------------------------------------------------------------------------
module tb_aes_round_sequencer;
   localparam int LENGTH = 128;
   localparam int NR     = 10;
   localparam int RW     = 4;

   localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

   logic clk = 1'b0;
   logic rst = 1'b1;

   aes_round_sequencer_if #(.LENGTH(LENGTH), .RW(RW)) bus ();

   aes_round_sequencer #(.LENGTH(LENGTH), .NR(NR), .RW(RW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- AES-128 reference functions ----------------
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // S-box from its definition: GF(2^8) inverse (x^254) then the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] sq, inv;
      sq  = x;
      inv = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gmul(sq, sq);
         inv = gmul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] key_expand(input logic [127:0] k, input int r);
      logic [7:0]  rc;
      logic [31:0] rot, tmp, n0, n1, n2, n3;
      rc = 8'h01;
      for (int j = 1; j < r; j++) rc = xtime(rc);
      rot = {k[23:0], k[31:24]};
      tmp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rc, 24'h0};
      n0  = k[127:96] ^ tmp;
      n1  = k[95:64] ^ n0;
      n2  = k[63:32] ^ n1;
      n3  = k[31:0] ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   // Byte i of a block is bits [127-8i -: 8]; state element (row r, col c) is byte 4c+r.
   function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rk, input bit last);
      logic [7:0]   a[16];
      logic [7:0]   b[16];
      logic [7:0]   m0, m1, m2, m3;
      logic [127:0] o;
      for (int i = 0; i < 16; i++) a[i] = sbox(st[127-8*i -: 8]);
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            b[4*c+r] = a[4*((c+r)%4)+r];
      if (!last) begin
         for (int c = 0; c < 4; c++) begin
            m0 = b[4*c]; m1 = b[4*c+1]; m2 = b[4*c+2]; m3 = b[4*c+3];
            b[4*c]   = xtime(m0) ^ xtime(m1) ^ m1 ^ m2 ^ m3;
            b[4*c+1] = m0 ^ xtime(m1) ^ xtime(m2) ^ m2 ^ m3;
            b[4*c+2] = m0 ^ m1 ^ xtime(m2) ^ xtime(m3) ^ m3;
            b[4*c+3] = xtime(m0) ^ m0 ^ m1 ^ m2 ^ xtime(m3);
         end
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
      return o ^ rk;
   endfunction

   // External combinational round datapath.
   assign bus.dp_key_next   = key_expand(bus.dp_key, int'(bus.dp_round));
   assign bus.dp_state_next = aes_round(bus.dp_state, bus.dp_key_next, bus.dp_last);

   // ---------------- job-level model ----------------
   int           m_age   = -1;   // cycles since accept while a job runs, else -1
   bit           m_has   = 1'b0; // a finished result waits for the consumer
   logic [127:0] m_state = '0;
   logic [127:0] m_key   = '0;
   logic [127:0] m_ct    = '0;
   int           m_rnd;

   function automatic bit m_busy();
      return (m_age >= 0) || m_has;
   endfunction

   function automatic bit m_in_ready();
      return !bus.abort && (!m_busy() || (m_has && bus.out_ready));
   endfunction

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         m_age = -1; m_has = 1'b0; m_state = '0; m_key = '0; m_ct = '0;
      end else if (bus.abort) begin
         m_age = -1; m_has = 1'b0;
      end else if (bus.in_valid && m_in_ready()) begin
         m_state = bus.Plain_Text ^ bus.Key;
         m_key   = bus.Key;
         m_age   = 0;
         m_has   = 1'b0;
      end else if (m_age >= 0) begin
         m_rnd   = m_age + 1;
         m_key   = key_expand(m_key, m_rnd);
         m_state = aes_round(m_state, m_key, m_rnd == NR);
         if (m_rnd == NR) begin
            m_ct  = m_state;
            m_has = 1'b1;
            m_age = -1;
         end else begin
            m_age = m_age + 1;
         end
      end else if (m_has && bus.out_ready) begin
         m_has = 1'b0;
      end
   end

   // Compare process: every falling edge outside reset.
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         check("in_ready",  128'(bus.in_ready),  128'(m_in_ready()));
         check("out_valid", 128'(bus.out_valid), 128'(m_has));
         check("busy",      128'(bus.busy),      128'(m_busy()));
         check("dp_round",  128'(bus.dp_round),  (m_age >= 0) ? 128'(m_age + 1) : 128'(0));
         check("dp_last",   128'(bus.dp_last),   128'(m_age == NR - 1));
         check("cipher",    bus.Cipher_Text,     m_ct);
         check("dp_state",  bus.dp_state,        m_state);
         check("dp_key",    bus.dp_key,          m_key);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents a job and holds it until accepted; returns just after the accept edge.
   task automatic accept_job(input logic [127:0] pt, input logic [127:0] k);
      bit got;
      got = 1'b0;
      bus.Plain_Text = pt;
      bus.Key        = k;
      bus.in_valid   = 1'b1;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         got = bus.in_ready;
         tick();
      end
      bus.in_valid = 1'b0;
      check("accept", 128'(got), 128'(1));
   endtask

   // Follows rounds 1..NR after an accept; returns on the falling edge where out_valid is seen.
   task automatic wait_result(input string tag, input logic [127:0] exp_ct, input logic [127:0] exp_key1);
      int lat;
      lat = -1;
      for (int i = 0; i < 20 && lat < 0; i++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            lat = i;
         end else begin
            check({tag, "_round"}, 128'(bus.dp_round), 128'(i + 1));
            check({tag, "_last"},  128'(bus.dp_last),  128'(i == NR - 1));
            if (i == 0) check({tag, "_key1"}, bus.dp_key, exp_key1);
            tick();
         end
      end
      check({tag, "_latency"}, 128'(lat), 128'(NR));
      check({tag, "_ct"}, bus.Cipher_Text, exp_ct);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int first, second;
      bus.in_valid   = 1'b0;
      bus.Plain_Text = '0;
      bus.Key        = '0;
      bus.abort      = 1'b0;
      bus.out_ready  = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_in_ready",  128'(bus.in_ready),  128'(1));
      check("rst_out_valid", 128'(bus.out_valid), 128'(0));
      check("rst_busy",      128'(bus.busy),      128'(0));
      check("rst_dp_last",   128'(bus.dp_last),   128'(0));
      check("rst_cipher",    bus.Cipher_Text,     128'(0));
      tick();

      // FIPS-197 C.1
      bus.out_ready = 1'b1;
      accept_job(PT_C1, KEY_C1);
      wait_result("c1", CT_C1, KEY_C1);
      tick();
      @(negedge clk);
      check("c1_idle_busy",  128'(bus.busy),      128'(0));
      check("c1_idle_valid", 128'(bus.out_valid), 128'(0));
      check("c1_hold_ct",    bus.Cipher_Text,     CT_C1);
      tick();

      // FIPS-197 B
      accept_job(PT_B, KEY_B);
      wait_result("b", CT_B, KEY_B);
      tick();

      // Back-to-back with in_valid held high
      bus.Plain_Text = PT_C1;
      bus.Key        = KEY_C1;
      bus.in_valid   = 1'b1;
      @(negedge clk);
      check("b2b_ready0", 128'(bus.in_ready), 128'(1));
      tick();
      bus.Plain_Text = PT_B;
      bus.Key        = KEY_B;
      first  = -1;
      second = -1;
      for (int i = 0; i < 30 && second < 0; i++) begin
         @(negedge clk);
         check("b2b_busy", 128'(bus.busy), 128'(1));
         if (bus.out_valid) begin
            if (first < 0) begin
               first = i;
               check("b2b_ct1",    bus.Cipher_Text,    CT_C1);
               check("b2b_ready1", 128'(bus.in_ready), 128'(1));
            end else begin
               second = i;
               check("b2b_ct2", bus.Cipher_Text, CT_B);
            end
         end
         if (second < 0) begin
            tick();
            if (first >= 0) bus.in_valid = 1'b0;
         end
      end
      bus.in_valid = 1'b0;
      check("b2b_first",   128'(first),          128'(NR));
      check("b2b_spacing", 128'(second - first), 128'(NR + 1));
      tick();

      // Backpressure: five stalled cycles, release on the sixth
      bus.out_ready = 1'b0;
      accept_job(PT_B, KEY_B);
      wait_result("bp", CT_B, KEY_B);
      check("bp_ready", 128'(bus.in_ready), 128'(0));
      for (int k = 1; k < 5; k++) begin
         tick();
         @(negedge clk);
         check("bp_hold_valid", 128'(bus.out_valid), 128'(1));
         check("bp_hold_ct",    bus.Cipher_Text,     CT_B);
         check("bp_ready",      128'(bus.in_ready),  128'(0));
      end
      tick();
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_ready", 128'(bus.in_ready), 128'(1));
      tick();
      @(negedge clk);
      check("bp_idle_busy",  128'(bus.busy),      128'(0));
      check("bp_idle_valid", 128'(bus.out_valid), 128'(0));
      tick();

      // Abort in round 5 with a competing request
      accept_job(PT_B, KEY_B);
      repeat (4) tick();
      bus.abort      = 1'b1;
      bus.in_valid   = 1'b1;
      bus.Plain_Text = PT_C1;
      bus.Key        = KEY_C1;
      @(negedge clk);
      check("abort_round", 128'(bus.dp_round), 128'(5));
      check("abort_ready", 128'(bus.in_ready), 128'(0));
      tick();
      bus.abort = 1'b0;
      @(negedge clk);
      check("abort_busy",  128'(bus.busy),      128'(0));
      check("abort_valid", 128'(bus.out_valid), 128'(0));
      check("abort_ready", 128'(bus.in_ready),  128'(1));
      check("abort_ct",    bus.Cipher_Text,     CT_B);
      tick();
      bus.in_valid = 1'b0;
      wait_result("post_abort", CT_C1, KEY_C1);
      tick();

      // Asynchronous reset between edges, mid-ROUND
      accept_job(PT_B, KEY_B);
      repeat (3) tick();
      #2 rst = 1'b1;
      #1;
      check("arst_out_valid", 128'(bus.out_valid), 128'(0));
      check("arst_busy",      128'(bus.busy),      128'(0));
      check("arst_cipher",    bus.Cipher_Text,     128'(0));
      check("arst_dp_state",  bus.dp_state,        128'(0));
      check("arst_dp_round",  128'(bus.dp_round),  128'(0));
      @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check("arst_in_ready", 128'(bus.in_ready), 128'(1));
      tick();
      accept_job(PT_B, KEY_B);
      wait_result("post_rst", CT_B, KEY_B);
      tick();
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      check("watchdog", 128'(0), 128'(1));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
- Iterative controller for AES-128 encryption on one shared round datapath: SubBytes, ShiftRows, optional MixColumns, AddRoundKey and KeyExpansion.
- The datapath is combinational and sits outside this block.
- This block owns the state and round-key registers, the round counter, the FSM and the valid/ready handshakes.
- It is the low-area alternative to the fully unrolled 11-stage cipher pipeline.

Parameters:
LENGTH, 128, width of block, key and state
NR, 10, number of rounds (AES-128); the round counter width is 4 bits, fixed
RW, 4, width of the round-number bus to the datapath

Ports:
clk  input  1  clock; all logic on the rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  Plain_Text and Key are valid
in_ready  output  1  block can accept a new job this cycle
Plain_Text  input  LENGTH  plaintext block
Key  input  LENGTH  cipher key
abort  input  1  synchronous abort; drops the current job
out_valid  output  1  Cipher_Text holds a completed result
out_ready  input  1  consumer accepts the result
Cipher_Text  output  LENGTH  registered ciphertext
busy  output  1  FSM is not IDLE
dp_state  output  LENGTH  state register driven to the datapath
dp_key  output  LENGTH  previous round key, key[r-1], driven to the datapath
dp_round  output  RW  current round r (1..NR), for Rcon selection; 0 when not in ROUND
dp_last  output  1  dp_round==NR; the datapath bypasses MixColumns
dp_state_next  input  LENGTH  datapath result: round(dp_state, key[r])
dp_key_next  input  LENGTH  datapath result: key[r] = expand(dp_key, r)

Behaviour:
- Interface: one clock (clk). Reset (rst) is asynchronous and active-high.
- Reset values: FSM=IDLE; round=0; state_reg=0; key_reg=0; Cipher_Text=0; out_valid=0; busy=0; dp_last=0.
- in_ready is combinational and equals 1 immediately after reset release.
- FSM states: IDLE, ROUND, DONE.
- in_ready = !abort && (FSM==IDLE || (FSM==DONE && out_ready)).
- Accept happens when in_valid && in_ready. On the accept edge:
  - state_reg <= Plain_Text ^ Key (initial AddRoundKey is done internally);
  - key_reg <= Key; round <= 1; FSM -> ROUND.
- ROUND, each cycle:
  - state_reg <= dp_state_next; key_reg <= dp_key_next.
  - If round==NR: Cipher_Text <= dp_state_next; out_valid <= 1; FSM -> DONE; round <= 0.
  - Otherwise round <= round+1.
- DONE:
  - out_valid=1; Cipher_Text is stable until the handshake completes.
  - out_valid && out_ready: out_valid <= 0. If in_valid is also high that cycle, the new job is accepted back-to-back and FSM -> ROUND; otherwise FSM -> IDLE.
- Latency: the accept edge is edge 0. out_valid rises after edge NR (10 cycles). Minimum job-to-job spacing is NR+1 cycles.
- Throughput with out_ready held high: one block per 11 cycles.
- Cipher_Text holds the last result after out_valid drops. It changes only on a round==NR edge.
- dp_round = round when FSM==ROUND, else 0. dp_last = (FSM==ROUND && round==NR).
- dp_state and dp_key are always driven from the registers.
- abort (synchronous, highest priority after rst):
  - From any state: FSM -> IDLE, round <= 0, out_valid <= 0.
  - Cipher_Text, state_reg and key_reg are not cleared.
  - in_ready=0 in the abort cycle, so an in_valid in that cycle is not accepted.
- Async rst mid-job: all registers go immediately to their reset values and the job is lost. No partial output appears.
- in_valid while ROUND: ignored (in_ready=0). The requester must hold its data until accepted.
- out_ready while not DONE: no effect.

Test Plan:
- FIPS-197 C.1 (datapath model in bench): Key=000102030405060708090a0b0c0d0e0f, Plain_Text=00112233445566778899aabbccddeeff -> out_valid 10 cycles after accept; Cipher_Text=69c4e0d86a7b0430d8cdb78070b4c55a; dp_round steps 1..10 with dp_last only at 10.
- FIPS-197 B: Key=2b7e151628aed2a6abf7158809cf4f3c, Plain_Text=3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32. Check dp_key during round 1 equals the input Key.
- Back-to-back: in_valid held high with both vectors, out_ready=1 -> accept in the DONE cycle; two results 11 cycles apart; busy never drops.
- Backpressure: out_ready=0 for 5 cycles after completion -> out_valid and Cipher_Text stable; in_ready=0; a 6th-cycle out_ready completes the transfer and moves FSM to IDLE.
- Abort at round 5 with in_valid=1 -> no accept that cycle; FSM=IDLE next cycle; out_valid stays 0; next job accepted the following cycle and produces the correct ciphertext.
- Assert rst asynchronously mid-ROUND (between edges) -> out_valid=0, busy=0, Cipher_Text=0 immediately; after release in_ready=1 and a new job completes correctly.
